pipeline_trace_tagger: RTL and testbench
========================================

// Module: pipeline_trace_tagger
// PURPOSE
//  Producer side of the per-instruction pipeline trace. Tags every fetched instruction
//  with a sequence ID and carries the tag through ID/EX/MEM/WB under the core's stall/flush.
//  At WB it emits one retire record per instruction into a small FIFO with a valid/ready
//  handshake, for a trace consumer (checker/printer) to drain.
// PARAMETERS
//  ID_W        8   sequence-ID width; wraps modulo 2^ID_W
//  CYC_W       16  cycle-counter width; wraps modulo 2^CYC_W
//  STALL_W     4   per-instruction stall counter width; saturates at all-ones
//  FIFO_DEPTH  4   retire-record FIFO entries (power of 2, >=2)
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous active-high reset
//  pc             in   16       PC presented by fetch this cycle
//  instr          in   16       instruction word presented by fetch this cycle
//  stall          in   1        hazard stall: freeze PC and IF/ID; insert bubble into EX
//  flush          in   1        squash the instruction being fetched this cycle
//  rec_ready      in   1        consumer accepts head record
//  rec_valid      out  1        FIFO non-empty
//  rec_id         out  ID_W     head: sequence ID
//  rec_pc         out  16       head: PC
//  rec_instr      out  16       head: instruction word
//  rec_fetch_cyc  out  CYC_W    head: cycle the instruction was fetched
//  rec_stall_cnt  out  STALL_W  head: cycles spent stalled in ID
//  rec_wb_cyc     out  CYC_W    head: cycle the instruction was in WB
//  rec_count      out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  overflow       out  1        sticky: a record was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset: cyc=0, next_id=0, all stage valids=0, FIFO empty, overflow=0.
//    All outputs 0. A reset mid-run discards in-flight tags and FIFO contents.
//  - cyc increments every non-reset cycle. The first cycle after reset is cyc 0.
//  - Fetch, at the edge ending cycle C:
//    - stall=0, flush=0: IF/ID <= {1, next_id, pc, instr, cyc, 0}; next_id++.
//    - stall=0, flush=1: IF/ID valid <= 0. No ID is consumed, so record IDs stay gap-free.
//    - stall=1: IF/ID holds its contents and stall_cnt++ (saturating) if valid.
//      flush is ignored; stall has priority. ID/EX receives a bubble.
//  - EX, MEM and WB stage registers advance every cycle. Only ID/EX sees the stall bubble.
//  - Latency: an instruction fetched in cycle C with no stalls is in WB in cycle C+4.
//    Its record is written at the end of C+4, and rec_valid rises in C+5 if the FIFO was empty.
//    Each ID-stage stall cycle adds 1.
//  - Retire: WB valid writes {id, pc, instr, fetch_cyc, stall_cnt, wb_cyc=cyc}.
//  - FIFO:
//    - pop when rec_valid & rec_ready. rec_* show the head entry and are 0 when empty.
//    - Full and push without pop: drop the record and set overflow (cleared only by rst).
//    - Full with push and pop in the same cycle: both happen, no drop.
//    - Empty and push: no bypass. The record appears the next cycle.
//    - rec_count is updated the same edge as push/pop.
//  - Wraparound: next_id and cyc wrap silently. stall_cnt saturates at 2^STALL_W-1.
// TESTING
//  1. rst, then 8 fetches pc=0,2,..,14, no stall/flush, rec_ready=1 -> records id0..7,
//     fetch_cyc 0..7, wb_cyc=fetch_cyc+4, stall_cnt 0, first rec_valid in cycle 5.
//  2. stall=1 for 2 cycles while id3 is in ID -> id3 stall_cnt=2, wb_cyc=fetch_cyc+6;
//     id4 fetch_cyc = id3 fetch_cyc+3; no bubble record is emitted.
//  3. flush=1 in cycle 6 (pc=0x000C) -> no record with pc 0x000C; next record id=6
//     for the fetch in cycle 7; IDs stay contiguous.
//  4. stall=1 & flush=1 in the same cycle -> flush ignored; ID instruction kept;
//     stall_cnt increments.
//  5. rec_ready=0, 6 retirements (FIFO_DEPTH=4) -> rec_count=4, overflow=1 after 5th;
//     then rec_ready=1 drains ids 0..3 in order; ids 4,5 lost.
//  6. rst asserted for 1 cycle mid-run with 3 in flight and 2 in FIFO -> rec_valid=0,
//     rec_count=0, overflow=0; next fetch gets id 0, fetch_cyc 0.

Source files
------------

// File: rtl/pipeline_trace_tagger.sv
// pipeline_trace_tagger
//   Tags each fetched instruction with a gap-free sequence ID, carries the tag
//   through ID/EX/MEM/WB under the core's stall/flush, and queues one retire
//   record per instruction at WB into a small valid/ready FIFO.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   pc, instr                     fetch-stage PC and instruction word
//   stall                         freeze IF/ID, inject bubble into EX
//   flush                         squash this cycle's fetch (ignored under stall)
//   rec_ready                     consumer accepts head record
//   rec_valid                     FIFO non-empty
//   rec_id/pc/instr/fetch_cyc/
//   rec_stall_cnt/rec_wb_cyc      head record fields, zero when empty
//   rec_count                     FIFO occupancy
//   overflow                      sticky: a record was dropped on a full FIFO
module pipeline_trace_tagger #(
  parameter int ID_W       = 8,
  parameter int CYC_W      = 16,
  parameter int STALL_W    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [15:0]                 pc,
  input  logic [15:0]                 instr,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        rec_ready,
  output logic                        rec_valid,
  output logic [ID_W-1:0]             rec_id,
  output logic [15:0]                 rec_pc,
  output logic [15:0]                 rec_instr,
  output logic [CYC_W-1:0]            rec_fetch_cyc,
  output logic [STALL_W-1:0]          rec_stall_cnt,
  output logic [CYC_W-1:0]            rec_wb_cyc,
  output logic [$clog2(FIFO_DEPTH):0] rec_count,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [15:0]        pc;
    logic [15:0]        instr;
    logic [CYC_W-1:0]   fcyc;
    logic [STALL_W-1:0] scnt;
  } tag_t;

  typedef struct packed {
    tag_t             tag;
    logic [CYC_W-1:0] wb_cyc;
  } rec_t;

  logic [CYC_W-1:0] r_cyc;
  logic [ID_W-1:0]  r_next_id;

  logic r_ifid_v, r_idex_v, r_exmem_v, r_memwb_v;
  tag_t r_ifid, r_idex, r_exmem, r_memwb;

  // ---------------------------------------------------------------------------
  // Tag pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc     <= '0;
      r_next_id <= '0;
      r_ifid_v  <= 1'b0;
      r_idex_v  <= 1'b0;
      r_exmem_v <= 1'b0;
      r_memwb_v <= 1'b0;
      r_ifid    <= '0;
      r_idex    <= '0;
      r_exmem   <= '0;
      r_memwb   <= '0;
    end else begin
      r_cyc <= r_cyc + CYC_W'(1);

      if (!stall) begin
        r_ifid_v <= ~flush;
        if (!flush) begin
          r_ifid    <= '{id: r_next_id, pc: pc, instr: instr, fcyc: r_cyc, scnt: '0};
          r_next_id <= r_next_id + ID_W'(1);
        end
      end else if (r_ifid_v && (r_ifid.scnt != '1)) begin
        // Held instruction accumulates stall time, saturating at all-ones.
        r_ifid.scnt <= r_ifid.scnt + STALL_W'(1);
      end

      // Only the ID->EX hop sees the stall bubble; later stages always advance.
      r_idex_v  <= r_ifid_v & ~stall;
      r_idex    <= r_ifid;
      r_exmem_v <= r_idex_v;
      r_exmem   <= r_idex;
      r_memwb_v <= r_exmem_v;
      r_memwb   <= r_exmem;
    end
  end

  // ---------------------------------------------------------------------------
  // Retire-record FIFO
  // ---------------------------------------------------------------------------
  rec_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_empty, w_full, w_pop, w_push, w_drop;
  rec_t w_wrec, w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = ~w_empty & rec_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign w_push  = r_memwb_v & (~w_full | w_pop);
  assign w_drop  = r_memwb_v & w_full & ~w_pop;
  assign w_wrec  = '{tag: r_memwb, wb_cyc: r_cyc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wptr] <= w_wrec;
  end

  always_comb begin
    w_head = '0;
    if (!w_empty) w_head = r_mem[r_rptr];
  end

  assign rec_valid     = ~w_empty;
  assign rec_id        = w_head.tag.id;
  assign rec_pc        = w_head.tag.pc;
  assign rec_instr     = w_head.tag.instr;
  assign rec_fetch_cyc = w_head.tag.fcyc;
  assign rec_stall_cnt = w_head.tag.scnt;
  assign rec_wb_cyc    = w_head.wb_cyc;
  assign rec_count     = r_count;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_pipeline_trace_tagger.sv
// Testbench for pipeline_trace_tagger: directed scenarios plus randomized
// stall/flush/ready/reset traffic, checked every cycle against a timestamp-based
// model (ID slot + list of issued instructions with their WB due cycle + record queue).
module tb_pipeline_trace_tagger;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = '0;
  logic [15:0] instr = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        rec_ready = 1'b0;
  logic        rec_valid;
  logic [7:0]  rec_id;
  logic [15:0] rec_pc;
  logic [15:0] rec_instr;
  logic [15:0] rec_fetch_cyc;
  logic [3:0]  rec_stall_cnt;
  logic [15:0] rec_wb_cyc;
  logic [2:0]  rec_count;
  logic        overflow;

  pipeline_trace_tagger #(
    .ID_W(8), .CYC_W(16), .STALL_W(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .stall(stall), .flush(flush),
    .rec_ready(rec_ready), .rec_valid(rec_valid), .rec_id(rec_id), .rec_pc(rec_pc),
    .rec_instr(rec_instr), .rec_fetch_cyc(rec_fetch_cyc), .rec_stall_cnt(rec_stall_cnt),
    .rec_wb_cyc(rec_wb_cyc), .rec_count(rec_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] fcyc;
    logic [3:0]  scnt;
    logic [15:0] wb;
  } rec_t;

  // Model state
  rec_t        m_fifo[$];
  rec_t        m_flight[$];
  rec_t        obs[$];
  rec_t        m_slot;
  bit          m_slot_v;
  logic [15:0] m_cyc;
  logic [7:0]  m_nid;
  bit          m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rec_t dut_head();
    rec_t r;
    r.id = rec_id; r.pc = rec_pc; r.instr = rec_instr;
    r.fcyc = rec_fetch_cyc; r.scnt = rec_stall_cnt; r.wb = rec_wb_cyc;
    return r;
  endfunction

  // One clock edge of the reference behaviour, using this cycle's inputs.
  task automatic model_edge();
    rec_t e;
    bit   pop;
    if (rst) begin
      m_fifo.delete(); m_flight.delete();
      m_slot_v = 0; m_cyc = '0; m_nid = '0; m_ovf = 0;
      return;
    end
    pop = (m_fifo.size() > 0) && rec_ready;
    if (pop) void'(m_fifo.pop_front());
    if (m_flight.size() > 0 && m_flight[0].wb == m_cyc) begin
      e = m_flight.pop_front();
      if (m_fifo.size() < 4) m_fifo.push_back(e);
      else m_ovf = 1;
    end
    if (stall) begin
      if (m_slot_v && m_slot.scnt != 4'hF) m_slot.scnt = m_slot.scnt + 4'd1;
    end else begin
      if (m_slot_v) begin
        // Leaving ID now: EX, MEM, then WB three cycles later.
        e = m_slot;
        e.wb = m_cyc + 16'd3;
        m_flight.push_back(e);
      end
      if (!flush) begin
        m_slot.id = m_nid; m_slot.pc = pc; m_slot.instr = instr;
        m_slot.fcyc = m_cyc; m_slot.scnt = '0; m_slot.wb = '0;
        m_slot_v = 1;
        m_nid = m_nid + 8'd1;
      end else begin
        m_slot_v = 0;
      end
    end
    m_cyc = m_cyc + 16'd1;
  endtask

  task automatic compare_all();
    rec_t x;
    x = '0;
    if (m_fifo.size() > 0) x = m_fifo[0];
    chk("rec_valid",     32'(rec_valid),     32'(m_fifo.size() > 0));
    chk("rec_id",        32'(rec_id),        32'(x.id));
    chk("rec_pc",        32'(rec_pc),        32'(x.pc));
    chk("rec_instr",     32'(rec_instr),     32'(x.instr));
    chk("rec_fetch_cyc", 32'(rec_fetch_cyc), 32'(x.fcyc));
    chk("rec_stall_cnt", 32'(rec_stall_cnt), 32'(x.scnt));
    chk("rec_wb_cyc",    32'(rec_wb_cyc),    32'(x.wb));
    chk("rec_count",     32'(rec_count),     32'(m_fifo.size()));
    chk("overflow",      32'(overflow),      32'(m_ovf));
  endtask

  task automatic cycle();
    if (rec_valid === 1'b1 && rec_ready) obs.push_back(dut_head());
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drv(input logic s, input logic f, input logic r, input logic [15:0] p);
    stall = s; flush = f; rec_ready = r; pc = p; instr = 16'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv(1'b0, 1'b1, 1'b1, 16'h0);
    cycle();
    rst = 1'b0;
    obs.delete();
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      drv(1'b0, 1'b1, r, 16'h0);
      cycle();
    end
  endtask

  function automatic int find_id(input logic [7:0] id);
    for (int i = 0; i < obs.size(); i++)
      if (obs[i].id == id) return i;
    return -1;
  endfunction

  initial begin
    int k;
    int n_pc;
    do_reset();

    // T1: straight-line fetch, latency and field values.
    for (int i = 0; i < 8; i++) begin
      drv(1'b0, 1'b0, 1'b1, 16'(2 * i));
      cycle();
      if (i == 3) chk("t1_valid_c4", 32'(rec_valid), 32'd0);
      if (i == 4) begin
        chk("t1_valid_c5", 32'(rec_valid), 32'd1);
        chk("t1_id_c5", 32'(rec_id), 32'd0);
        chk("t1_wb_c5", 32'(rec_wb_cyc), 32'd4);
      end
    end
    idle(8, 1'b1);
    chk("t1_nrec", 32'(obs.size()), 32'd8);
    for (int i = 0; i < obs.size() && i < 8; i++) begin
      chk("t1_id",   32'(obs[i].id),   32'(i));
      chk("t1_pc",   32'(obs[i].pc),   32'(2 * i));
      chk("t1_fcyc", 32'(obs[i].fcyc), 32'(i));
      chk("t1_wb",   32'(obs[i].wb),   32'(i + 4));
      chk("t1_scnt", 32'(obs[i].scnt), 32'd0);
    end

    // T2 + T4: two stall cycles on id3, the second one also flushed.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drv(i == 4 || i == 5, i == 5, 1'b1, 16'(2 * i));
      cycle();
    end
    idle(10, 1'b1);
    chk("t2_nrec", 32'(obs.size()), 32'd8);
    for (int i = 0; i < obs.size(); i++) chk("t2_contig", 32'(obs[i].id), 32'(i));
    k = find_id(8'd3);
    chk("t2_id3_found", 32'(k >= 0), 32'd1);
    if (k >= 0) begin
      chk("t2_id3_scnt", 32'(obs[k].scnt), 32'd2);
      chk("t2_id3_fcyc", 32'(obs[k].fcyc), 32'd3);
      chk("t2_id3_wb",   32'(obs[k].wb),   32'd9);
    end
    k = find_id(8'd4);
    chk("t2_id4_found", 32'(k >= 0), 32'd1);
    if (k >= 0) begin
      chk("t2_id4_fcyc", 32'(obs[k].fcyc), 32'd6);
      chk("t2_id4_pc",   32'(obs[k].pc),   32'h000C);
    end

    // T3: flush the fetch of pc 0x000C in cycle 6.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drv(1'b0, i == 6, 1'b1, 16'(2 * i));
      cycle();
    end
    idle(10, 1'b1);
    chk("t3_nrec", 32'(obs.size()), 32'd9);
    n_pc = 0;
    for (int i = 0; i < obs.size(); i++) begin
      chk("t3_contig", 32'(obs[i].id), 32'(i));
      if (obs[i].pc == 16'h000C) n_pc++;
    end
    chk("t3_no_pc0c", 32'(n_pc), 32'd0);
    k = find_id(8'd6);
    if (k >= 0) begin
      chk("t3_id6_pc",   32'(obs[k].pc),   32'h000E);
      chk("t3_id6_fcyc", 32'(obs[k].fcyc), 32'd7);
    end else chk("t3_id6_found", 32'd0, 32'd1);

    // T5: consumer blocked, six retirements into a 4-deep FIFO.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drv(1'b0, 1'b0, 1'b0, 16'(2 * i));
      cycle();
    end
    for (int j = 0; j < 4; j++) begin
      drv(1'b0, 1'b1, 1'b0, 16'h0);
      cycle();
      if (j == 1) begin
        chk("t5_cnt_c8", 32'(rec_count), 32'd4);
        chk("t5_ovf_c8", 32'(overflow), 32'd0);
      end
      if (j == 2) chk("t5_ovf_c9", 32'(overflow), 32'd1);
    end
    chk("t5_cnt", 32'(rec_count), 32'd4);
    idle(6, 1'b1);
    chk("t5_nrec", 32'(obs.size()), 32'd4);
    for (int i = 0; i < obs.size(); i++) chk("t5_order", 32'(obs[i].id), 32'(i));
    chk("t5_ovf_sticky", 32'(overflow), 32'd1);

    // T6: reset mid-run with records queued and instructions in flight.
    for (int i = 0; i < 5; i++) begin
      drv(1'b0, 1'b0, 1'b0, 16'(16'h20 + 2 * i));
      cycle();
    end
    drv(1'b0, 1'b1, 1'b0, 16'h0);
    cycle();
    chk("t6_cnt_pre", 32'(rec_count), 32'd2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_valid", 32'(rec_valid), 32'd0);
    chk("t6_cnt",   32'(rec_count), 32'd0);
    chk("t6_ovf",   32'(overflow),  32'd0);
    obs.delete();
    drv(1'b0, 1'b0, 1'b1, 16'h0040);
    cycle();
    idle(8, 1'b1);
    chk("t6_nrec", 32'(obs.size()), 32'd1);
    if (obs.size() > 0) begin
      chk("t6_id",   32'(obs[0].id),   32'd0);
      chk("t6_pc",   32'(obs[0].pc),   32'h0040);
      chk("t6_fcyc", 32'(obs[0].fcyc), 32'd0);
    end

    // Stall-counter saturation: 20 stall cycles on id0.
    do_reset();
    drv(1'b0, 1'b0, 1'b1, 16'h0100);
    cycle();
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, 1'b0, 1'b1, 16'h0);
      cycle();
    end
    idle(8, 1'b1);
    if (obs.size() > 0) begin
      chk("sat_scnt", 32'(obs[0].scnt), 32'hF);
      chk("sat_wb",   32'(obs[0].wb),   32'd24);
    end else chk("sat_found", 32'd0, 32'd1);

    // Randomized traffic, including occasional resets and ready droughts.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drv($urandom_range(0, 3) == 0,
          $urandom_range(0, 5) == 0,
          ((i / 100) % 3 == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7),
          16'($urandom));
      cycle();
    end
    rst = 1'b0;
    idle(20, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
